md_sched: RTL

- Issue/stall scheduler for the multiply/divide unit in the E stage of the P7 pipeline.
- Decides when a mult/div/mfhi/mflo/mthi/mtlo in E may touch the unit, and drives the unit's start, control, read-enable and write-enable.
- Raises `stall` to freeze F/D/E while the unit is occupied.
- Models unit latency with an internal countdown and cross-checks it against the unit's `busy`, flagging any mismatch.

---
 rtl/md_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// rtl/md_sched.sv - issue/stall scheduler for the E-stage multiply/divide unit
//
// Decides when an MD-class op in E may use the multiply/divide unit, drives
// the unit's start/control/read/write enables, stalls F/D/E while the unit
// is occupied, and cross-checks a modelled latency against md_busy.
//
// Optional feature macro: MD_SCHED_PERF_EN (stall-cycle counter on
// perf_stall_cnt; tied to zero when undefined).
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   op_valid       E holds an MD-class instruction
//   op_kind        00 start-mul, 01 start-div, 10 mf hi/lo, 11 mt hi/lo
//   op_ctrl        MD control code forwarded on start
//   op_sel         01 hi, 10 lo for read/write kinds
//   int_req        interrupt/exception request from CP0
//   md_busy        unit busy
//   md_start       single-cycle unit start
//   md_ctrl        unit control code (000 when not issuing)
//   md_re / md_we  unit read / write enables
//   stall          freeze F/D/E this cycle
//   err_lat        sticky latency-mismatch / watchdog flag
//   perf_stall_cnt stall-cycle counter

module md_sched #(
    parameter int MUL_LAT    = 5,
    parameter int DIV_LAT    = 10,
    parameter int WDOG_SLACK = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op_kind,
    input  logic [2:0]  op_ctrl,
    input  logic [1:0]  op_sel,
    input  logic        int_req,
    input  logic        md_busy,
    output logic        md_start,
    output logic [2:0]  md_ctrl,
    output logic [1:0]  md_re,
    output logic [1:0]  md_we,
    output logic        stall,
    output logic        err_lat,
    output logic [31:0] perf_stall_cnt
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam int WW      = $clog2(WDOG_SLACK + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [WW-1:0]   wdog_q;
    logic            err_lat_q;
    logic [CW-1:0]   cnt_load_d;
    logic            free;
    logic            issue;
    logic            mul_class;

    assign free = (state_q == IDLE);

    // Outputs are gated by reset so they drop the instant reset asserts;
    // the unit shares this reset and must not see a start while held.
    assign issue = reset & op_valid & ~op_kind[1] & free & ~int_req;

    assign mul_class  = (op_ctrl == 3'b000) || (op_ctrl == 3'b001) || (op_ctrl == 3'b100);
    assign cnt_load_d = mul_class ? CW'(MUL_LAT) : CW'(DIV_LAT);

    assign md_start = issue;
    assign md_ctrl  = issue ? op_ctrl : 3'b000;
    assign md_re    = (reset && op_valid && op_kind == 2'b10 && free) ? op_sel : 2'b00;
    assign md_we    = (reset && op_valid && op_kind == 2'b11 && free && !int_req) ? op_sel : 2'b00;
    assign stall    = reset & op_valid & ~free;
    assign err_lat  = err_lat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wdog_q    <= '0;
            err_lat_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        state_q <= RUN;
                        cnt_q   <= cnt_load_d;
                    end
                end
                RUN: begin
                    // Unit went idle before the model expected it to.
                    if (!md_busy && cnt_q > CW'(1)) begin
                        err_lat_q <= 1'b1;
                    end
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= md_busy ? TAIL : IDLE;
                        wdog_q  <= '0;
                    end
                end
                TAIL: begin
                    if (!md_busy) begin
                        state_q <= IDLE;
                        wdog_q  <= '0;
                    end else if (wdog_q == WW'(WDOG_SLACK)) begin
                        // Slack exhausted: flag it and free the pipeline anyway.
                        err_lat_q <= 1'b1;
                        state_q   <= IDLE;
                        wdog_q    <= '0;
                    end else begin
                        wdog_q <= wdog_q + WW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    wdog_q  <= '0;
                end
            endcase
        end
    end

`ifdef MD_SCHED_PERF_EN
    logic [31:0] perf_q;
    logic [31:0] perf_d;

    assign perf_d = perf_q + {31'd0, stall};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
